// File: rtl/game_tick_scheduler_if.sv
// Control and status bundle for the game tick scheduler.
// The master side is the game core (or bench); the slave side is the scheduler.
interface game_tick_scheduler_if #(
  parameter int LEVEL_W = 4
) ();
  logic               start;
  logic               stop;
  logic               pause_req;
  logic               level_valid;
  logic [LEVEL_W-1:0] level;
  logic               level_ready;
  logic               pix_en;
  logic               digit_tick;
  logic               sec_tick;
  logic               fall_tick;
  logic               running;
  logic               paused;
  logic [26:0]        fall_div;

  modport master (
    output start, stop, pause_req, level_valid, level,
    input  level_ready, pix_en, digit_tick, sec_tick, fall_tick,
           running, paused, fall_div
  );

  modport slave (
    input  start, stop, pause_req, level_valid, level,
    output level_ready, pix_en, digit_tick, sec_tick, fall_tick,
           running, paused, fall_div
  );
endinterface

// File: rtl/game_tick_scheduler.sv
// Game tick scheduler: derives single-cycle enable strobes from clk and
// sequences game time through IDLE/RUN/PAUSE, with a level handshake that
// retimes the block-fall period only on interval boundaries.
//
//   state | meaning
//   IDLE  | no game; fall/sec counters held at 0
//   RUN   | game time advancing; fall/sec counters count
//   PAUSE | game time frozen; fall/sec counters hold their value
module game_tick_scheduler #(
  parameter int BASE_FALL_DIV = 8000000,
  parameter int FALL_STEP     = 500000,
  parameter int MIN_FALL_DIV  = 1000000,
  parameter int DIGIT_DIV     = 200000,
  parameter int SEC_DIV       = 100000000,
  parameter int LEVEL_W       = 4
) (
  input logic                  clk,
  input logic                  rst,
  game_tick_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [26:0] BASE_DIV  = 27'(BASE_FALL_DIV);
  localparam logic [26:0] MIN_DIV   = 27'(MIN_FALL_DIV);
  localparam logic [26:0] DIGIT_M1  = 27'(DIGIT_DIV - 1);
  localparam logic [26:0] SEC_M1    = 27'(SEC_DIV - 1);
  localparam logic [31:0] BASE32    = 32'(BASE_FALL_DIV);
  localparam logic [31:0] STEP32    = 32'(FALL_STEP);
  localparam logic [31:0] CLAMP_LIM = 32'(BASE_FALL_DIV - MIN_FALL_DIV);

  state_t      state_q, state_d;
  logic [1:0]  pix_cnt;
  logic [26:0] digit_cnt;
  logic [26:0] fall_cnt;
  logic [26:0] sec_cnt;
  logic [26:0] pend_div;
  logic [26:0] pend_calc;
  logic [31:0] step_prod;
  logic        pending;
  logic        fall_wrap, sec_wrap, xfer, load, clear_game;

  // The >= compare keeps a counter held in PAUSE from running away when a
  // shorter period is loaded underneath it.
  assign fall_wrap  = (state_q == RUN) && (fall_cnt >= bus.fall_div - 27'd1);
  assign sec_wrap   = (state_q == RUN) && (sec_cnt >= SEC_M1);
  assign clear_game = (state_q == IDLE) || (state_d == IDLE);
  assign xfer       = bus.level_valid && bus.level_ready;
  // Pending period applies at an interval boundary while running, otherwise at once.
  assign load       = pending && ((state_q != RUN) || fall_wrap);
  assign step_prod  = 32'(bus.level) * STEP32;
  assign pend_calc  = (step_prod > CLAMP_LIM) ? MIN_DIV : 27'(BASE32 - step_prod);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; stop overrides everything, start outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start)      state_d = RUN;
        RUN:     if (bus.pause_req)  state_d = PAUSE;
        PAUSE:   if (!bus.pause_req) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Free-running pixel and digit strobes, never gated by game state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt        <= '0;
      bus.pix_en     <= 1'b0;
      digit_cnt      <= '0;
      bus.digit_tick <= 1'b0;
    end else begin
      pix_cnt    <= pix_cnt + 2'd1;
      bus.pix_en <= (pix_cnt == 2'd3);
      if (digit_cnt == DIGIT_M1) begin
        digit_cnt      <= '0;
        bus.digit_tick <= 1'b1;
      end else begin
        digit_cnt      <= digit_cnt + 27'd1;
        bus.digit_tick <= 1'b0;
      end
    end
  end

  // Game-time counters: advance in RUN, hold in PAUSE, clear in IDLE and on game start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fall_cnt      <= '0;
      sec_cnt       <= '0;
      bus.fall_tick <= 1'b0;
      bus.sec_tick  <= 1'b0;
    end else begin
      bus.fall_tick <= fall_wrap;
      bus.sec_tick  <= sec_wrap;
      if (clear_game || fall_wrap)  fall_cnt <= '0;
      else if (state_q == RUN)      fall_cnt <= fall_cnt + 27'd1;
      if (clear_game || sec_wrap)   sec_cnt <= '0;
      else if (state_q == RUN)      sec_cnt <= sec_cnt + 27'd1;
    end
  end

  // Level handshake: capture the new period, then swap it in at the right moment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_div        <= BASE_DIV;
      pending         <= 1'b0;
      bus.fall_div    <= BASE_DIV;
      bus.level_ready <= 1'b1;
    end else begin
      if (load) begin
        bus.fall_div <= pend_div;
        pending      <= 1'b0;
      end
      if (xfer) begin
        pend_div <= pend_calc;
        pending  <= 1'b1;
      end
      // Ready lags the load by one cycle so the new period is visible first.
      bus.level_ready <= xfer ? 1'b0 : !pending;
    end
  end

  // Registered state flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.running <= 1'b0;
      bus.paused  <= 1'b0;
    end else begin
      bus.running <= (state_d == RUN);
      bus.paused  <= (state_d == PAUSE);
    end
  end
endmodule

// File: tb/tb_game_tick_scheduler.sv
// Randomized self-checking bench for game_tick_scheduler against a
// cycle-level behavioural model of game time, strobes and level handshake.
module tb_game_tick_scheduler;
  localparam int BASE = 20;
  localparam int STEP = 4;
  localparam int MIND = 6;
  localparam int DIG  = 5;
  localparam int SEC  = 50;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic clk = 1'b0;
  logic rst;

  game_tick_scheduler_if #(.LEVEL_W(4)) bus ();

  game_tick_scheduler #(
    .BASE_FALL_DIV(BASE), .FALL_STEP(STEP), .MIN_FALL_DIV(MIND),
    .DIGIT_DIV(DIG), .SEC_DIV(SEC), .LEVEL_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model state
  int m_st, m_fe, m_se, m_div, m_pend, m_cyc;
  bit m_pending, m_ready, e_ft, e_st;
  bit p_lvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_fe = 0; m_se = 0; m_div = BASE; m_pend = BASE;
    m_cyc = 0; m_pending = 0; m_ready = 1; e_ft = 0; e_st = 0;
  endtask

  function automatic int period_for(input int l);
    int prod;
    prod = l * STEP;
    return (prod > BASE - MIND) ? MIND : BASE - prod;
  endfunction

  // One clock edge of game behaviour, given the inputs presented before it.
  task automatic model_step(input bit s, input bit t, input bit p, input bit lv, input int l);
    int  nxt;
    bit  wrap, xfer;
    nxt = m_st;
    if (t) nxt = M_IDLE;
    else if (m_st == M_IDLE && s) nxt = M_RUN;
    else if (m_st == M_RUN && p) nxt = M_PAUSE;
    else if (m_st == M_PAUSE && !p) nxt = M_RUN;

    e_ft = 0; e_st = 0; wrap = 0;
    if (m_st == M_RUN) begin
      m_fe++;
      if (m_fe >= m_div) begin e_ft = 1; m_fe = 0; wrap = 1; end
      m_se++;
      if (m_se >= SEC) begin e_st = 1; m_se = 0; end
    end
    if (nxt == M_IDLE || m_st == M_IDLE) begin m_fe = 0; m_se = 0; end

    xfer = lv && m_ready;
    if (m_pending && (m_st != M_RUN || wrap)) begin
      m_div = m_pend;
      m_pending = 0;
      m_ready = 0;
    end else begin
      m_ready = !m_pending;
    end
    if (xfer) begin
      m_pend = period_for(l);
      m_pending = 1;
      m_ready = 0;
    end
    m_st = nxt;
    m_cyc++;
  endtask

  task automatic compare();
    chk("pix_en",      32'(bus.pix_en),      32'(m_cyc > 0 && m_cyc % 4 == 0));
    chk("digit_tick",  32'(bus.digit_tick),  32'(m_cyc > 0 && m_cyc % DIG == 0));
    chk("fall_tick",   32'(bus.fall_tick),   32'(e_ft));
    chk("sec_tick",    32'(bus.sec_tick),    32'(e_st));
    chk("running",     32'(bus.running),     32'(m_st == M_RUN));
    chk("paused",      32'(bus.paused),      32'(m_st == M_PAUSE));
    chk("level_ready", 32'(bus.level_ready), 32'(m_ready));
    chk("fall_div",    32'(bus.fall_div),    32'(m_div));
  endtask

  // Drive inputs (called just after a falling edge), step the model, check at the next falling edge.
  task automatic cyc(input bit s, input bit t, input bit p, input bit lv, input int l);
    bus.start = s; bus.stop = t; bus.pause_req = p;
    bus.level_valid = lv; bus.level = 4'(l);
    model_step(s, t, p, lv, l);
    @(negedge clk);
    compare();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    bus.start = 0; bus.stop = 0; bus.pause_req = 0; bus.level_valid = 0; bus.level = '0;
    model_reset();
    p_lvl = 0;
    repeat (2) @(negedge clk);
    compare();
    rst = 1'b0;

    // Idle: only pix/digit strobes
    idle_cycles(200);

    // Start and run through several fall intervals and one second
    cyc(1, 0, 0, 0, 0);
    idle_cycles(69);

    // Level 2 mid-interval, then level 9 clamps
    cyc(0, 0, 0, 1, 2);
    idle_cycles(45);
    chk("div_lvl2", 32'(bus.fall_div), 32'd12);
    cyc(0, 0, 0, 1, 9);
    idle_cycles(30);
    chk("div_lvl9", 32'(bus.fall_div), 32'd6);

    // Pause for 30 cycles
    idle_cycles(10);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1, 0, 0);
    idle_cycles(20);

    // stop with pause_req high, then start+stop together in IDLE
    cyc(0, 1, 1, 0, 0);
    idle_cycles(3);
    cyc(1, 1, 0, 0, 0);
    idle_cycles(2);
    chk("start_stop_idle", 32'(bus.running), 32'd0);

    // Level transfer exactly on a wrap cycle
    cyc(1, 0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_st == M_RUN && m_fe == m_div - 1 && m_ready) begin
        cyc(0, 0, 0, 1, 1);
        found = 1;
      end else begin
        cyc(0, 0, 0, 0, 0);
      end
    end
    chk("wrap_xfer_found", 32'(found), 32'd1);
    idle_cycles(40);

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      bit s, t, lv;
      int l;
      s = ($urandom_range(0, 19) == 0);
      t = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) p_lvl = !p_lvl;
      lv = ($urandom_range(0, 9) == 0) ||
           (m_st == M_RUN && m_fe == m_div - 1 && $urandom_range(0, 1) == 1);
      l = $urandom_range(0, 15);
      cyc(s, t, p_lvl, lv, l);
    end

    // Async reset mid-RUN with a level pending
    p_lvl = 0;
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle_cycles(5);
    cyc(0, 0, 0, 1, 3);
    chk("pending_before_rst", 32'(bus.level_ready), 32'd0);
    #2 rst = 1'b1;
    bus.level_valid = 0;
    #1;
    chk("rst_fall_div", 32'(bus.fall_div),    32'd20);
    chk("rst_ready",    32'(bus.level_ready), 32'd1);
    chk("rst_running",  32'(bus.running),     32'd0);
    chk("rst_pix_en",   32'(bus.pix_en),      32'd0);
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 39) == 0) p_lvl = !p_lvl;
      cyc(($urandom_range(0, 9) == 0), 1'b0, p_lvl, ($urandom_range(0, 7) == 0), $urandom_range(0, 15));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/game_tick_scheduler.md
# game_tick_scheduler

Central timing controller for the Sky-Stacker game core. It derives single-cycle enable strobes from the 100 MHz system clock for pixel, digit-multiplex, one-second and block-fall events. These strobes replace divided clocks, so all consumers stay in the `clk` domain. The block sequences game time through IDLE/RUN/PAUSE states and accepts level changes over a valid/ready handshake, retiming the fall rate without glitches.

## Interface
- `BASE_FALL_DIV`, 8000000 — fall period in clk cycles at level 0 (12.5 Hz).
- `FALL_STEP`, 500000 — period reduction per level.
- `MIN_FALL_DIV`, 1000000 — floor for the fall period.
- `DIGIT_DIV`, 200000 — digit_tick period in cycles.
- `SEC_DIV`, 100000000 — sec_tick period in cycles.
- `LEVEL_W`, 4 — level field width.
- `clk` in 1 — system clock, 100 MHz.
- `rst` in 1 — reset, asynchronous, active-high.
- `start` in 1 — one-cycle pulse; begins a game from IDLE.
- `stop` in 1 — one-cycle pulse; returns to IDLE from any state.
- `pause_req` in 1 — level-sensitive; high requests PAUSE, low requests RUN.
- `level_valid` in 1 — new level offered.
- `level` in LEVEL_W — requested level, sampled on transfer.
- `level_ready` out 1 — high when no level change is pending.
- `pix_en` out 1 — one-cycle strobe, one cycle in every 4 (25 MHz).
- `digit_tick` out 1 — one-cycle strobe every DIGIT_DIV cycles.
- `sec_tick` out 1 — one-cycle strobe every SEC_DIV cycles of RUN time.
- `fall_tick` out 1 — one-cycle strobe every fall_div cycles of RUN time.
- `running` out 1 — state == RUN.
- `paused` out 1 — state == PAUSE.
- `fall_div` out 27 — active fall period.

## Operation
- **States:** IDLE, RUN, PAUSE. Transitions are evaluated in this priority order:
  - Any state + `stop` → IDLE.
  - IDLE + `start` → RUN.
  - RUN + `pause_req` → PAUSE.
  - PAUSE + !`pause_req` → RUN.
  - `start` outside IDLE is ignored.
- **Free-running strobes:** `pix_en` and `digit_tick` run in all states and are never gated. Only `rst` clears them.
- **Game counters:** the fall and sec counters count only in RUN. They hold their value in PAUSE. They clear to 0 in IDLE and on the IDLE→RUN transition.
- **Fall counter:** when `fall_cnt == fall_div-1` in RUN, `fall_cnt` goes to 0 and `fall_tick` fires. The sec counter wraps the same way using SEC_DIV.
- **Level handshake:** a transfer occurs when `level_valid && level_ready`. On transfer:
  - `pend_div` is computed as `BASE_FALL_DIV - level*FALL_STEP`, using 32-bit arithmetic.
  - If `level*FALL_STEP > BASE_FALL_DIV - MIN_FALL_DIV`, `pend_div` clamps to MIN_FALL_DIV.
  - `level_ready` drops the next cycle.
- **Applying the pending period:** `pend_div` loads into `fall_div` on the next fall-counter wrap. In IDLE or PAUSE it loads on the cycle after the transfer. `level_ready` returns high the cycle after the load.
- **Transfer coinciding with a wrap:** the new value stays pending and applies at the following wrap, never in the same cycle as the transfer.
- **`stop` with a level pending:** the pending value is applied, not discarded. IDLE loads it on the next cycle.

## Timing
- **Reset values:**
  - state IDLE.
  - All strobes 0; `running` 0; `paused` 0.
  - `level_ready` 1.
  - `fall_div` = BASE_FALL_DIV.
  - All counters 0.
- **Registered outputs:** all outputs are registered. Each strobe is exactly 1 cycle wide.
- **`running` latency:** `running` rises 1 cycle after the `start` pulse.
- **First `fall_tick`:** it is high exactly `fall_div` cycles after `running` rises, then every `fall_div` RUN cycles.
- **Pause:** PAUSE cycles are excluded from the interval count. No strobe is lost or duplicated across a pause.
- **`pause_req` latency:** `paused` rises 1 cycle after `pause_req` is sampled high in RUN.
- **`pix_en`:** first high on the 4th cycle after reset deassertion, then every 4 cycles.
- **`digit_tick`:** first high on cycle DIGIT_DIV after reset deassertion, then every DIGIT_DIV cycles.
- **Reset mid-game:** asynchronous; all outputs go to their reset values immediately. Any pending level is discarded.

## Test plan
Run with `BASE_FALL_DIV`=20, `FALL_STEP`=4, `MIN_FALL_DIV`=6, `DIGIT_DIV`=5, `SEC_DIV`=50.

- **Reset and free-running strobes:** release `rst` → `pix_en` high on cycles 4, 8, 12; `digit_tick` high on cycles 5, 10; `fall_tick`/`sec_tick` stay 0 for 200 cycles in IDLE.
- **Start:** `start` pulse at cycle T → `running`=1 at T+1; `fall_tick` at T+21, T+41, T+61; `sec_tick` at T+51.
- **Pause:** run 10 RUN cycles, then assert `pause_req` for 30 cycles, then deassert → next `fall_tick` after exactly 10 further RUN cycles; `paused` high for 30 cycles; no strobes during PAUSE.
- **Level change and clamp:**
  - `level`=2 transferred mid-interval → `level_ready` low; the current interval completes at 20 cycles; the following interval is 12 cycles; `fall_div`=12.
  - `level`=9 → clamps to `fall_div`=6.
- **Simultaneous events:**
  - `stop` together with `pause_req` high in RUN → IDLE; counters 0.
  - `start` together with `stop` in IDLE → stays IDLE.
  - Level transfer on a wrap cycle → applied at the next wrap, not the current one.
- **Async reset mid-RUN with a level pending:** `rst` pulse → `fall_div`=20, `level_ready`=1, `running`=0 in the same cycle.
